// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one single-cycle combinational ALU between NREQ
//            requesters. A round-robin arbiter picks one valid request per
//            accepting cycle, drives its payload onto the ALU inputs, and
//            captures the ALU result/zero flag into a one-entry response
//            buffer. The buffer is held until its owner consumes it. A new
//            grant may be issued in the same cycle the buffer is consumed,
//            so back-to-back operation sustains one op per cycle.
// Ports    :
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   req_valid_i/ready_o    per-requester request handshake
//   req_ctrl_i             4-bit ALU op per requester, packed [4k+3:4k]
//   req_in1_i/in2_i        32-bit operands per requester, packed [32k+31:32k]
//   rsp_valid_o/ready_i    per-requester response handshake (one-hot valid)
//   rsp_result_o/zero_o    buffered ALU result and zero flag
//   grant_id_o             index of the requester owning the buffer
//   busy_o                 response buffer occupied
//   alu_ctrl_o/in1_o/in2_o to the shared ALU (all zero when not issuing)
//   alu_result_i/zero_i    from the shared ALU
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [4*NREQ-1:0]    req_ctrl_i,
    input  logic [32*NREQ-1:0]   req_in1_i,
    input  logic [32*NREQ-1:0]   req_in2_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [31:0]          rsp_result_o,
    output logic                 rsp_zero_o,
    output logic [IDW-1:0]       grant_id_o,
    output logic                 busy_o,
    output logic [3:0]           alu_ctrl_o,
    output logic [31:0]          alu_in1_o,
    output logic [31:0]          alu_in2_o,
    input  logic [31:0]          alu_result_i,
    input  logic                 alu_zero_i
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // One extra bit so pointer + offset (at most 2*NREQ-1) never overflows.
    localparam logic [IDW:0]   NREQ_EXT  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] PTR_RESET = IDW'(NREQ - 1);

    state_t          state_q,  state_d;
    logic [IDW-1:0]  ptr_q,    ptr_d;
    logic [IDW-1:0]  grant_q,  grant_d;
    logic [31:0]     result_q, result_d;
    logic            zero_q,   zero_d;

    logic [3:0]      ctrl_arr [NREQ];
    logic [31:0]     in1_arr  [NREQ];
    logic [31:0]     in2_arr  [NREQ];
    logic [IDW:0]    cand_sum [NREQ];
    logic [IDW-1:0]  cand_idx [NREQ];

    logic            found;
    logic [IDW-1:0]  winner;
    logic            accept;
    logic            issue;

    // Unpack per-requester payloads and precompute the search order:
    // cand_idx[k] is the requester examined k-th, starting at pointer+1.
    for (genvar k = 0; k < NREQ; k++) begin : g_req
        assign ctrl_arr[k] = req_ctrl_i[4*k +: 4];
        assign in1_arr[k]  = req_in1_i[32*k +: 32];
        assign in2_arr[k]  = req_in2_i[32*k +: 32];
        assign cand_sum[k] = {1'b0, ptr_q} + (IDW+1)'(k + 1);
        assign cand_idx[k] = (cand_sum[k] >= NREQ_EXT) ? IDW'(cand_sum[k] - NREQ_EXT)
                                                       : IDW'(cand_sum[k]);
    end

    // Walk the order from last to first so the earliest valid candidate
    // is the one left standing.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[cand_idx[k]]) begin
                found  = 1'b1;
                winner = cand_idx[k];
            end
        end
    end

    // The buffer can take a new result when empty, or when its owner is
    // draining it this very cycle.
    assign accept = (state_q == ST_IDLE) ||
                    ((state_q == ST_HOLD) && rsp_ready_i[grant_q]);
    assign issue  = accept && found;

    assign req_ready_o = issue ? (NREQ'(1) << winner) : '0;

    // ALU inputs are forced to zero whenever nothing is issued.
    assign alu_ctrl_o = issue ? ctrl_arr[winner] : 4'b0000;
    assign alu_in1_o  = issue ? in1_arr[winner]  : 32'd0;
    assign alu_in2_o  = issue ? in2_arr[winner]  : 32'd0;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (issue) begin
            state_d  = ST_HOLD;
            ptr_d    = winner;
            grant_d  = winner;
            result_d = alu_result_i;
            zero_d   = alu_zero_i;
        end else if ((state_q == ST_HOLD) && rsp_ready_i[grant_q]) begin
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RESET;
            grant_q  <= '0;
            result_q <= 32'd0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy_o       = (state_q == ST_HOLD);
    assign rsp_valid_o  = busy_o ? (NREQ'(1) << grant_q) : '0;
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;
    assign grant_id_o   = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with two requesters. A
//            reference ALU answers the DUT's ALU port; a transaction-level
//            model predicts handshakes, ALU drive and the response buffer,
//            and is compared on every falling edge. Directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [3:0]        p_ctrl [NREQ];
    logic [31:0]       p_a    [NREQ];
    logic [31:0]       p_b    [NREQ];
    logic [4*NREQ-1:0] req_ctrl;
    logic [32*NREQ-1:0] req_in1;
    logic [32*NREQ-1:0] req_in2;
    logic [31:0]       rsp_result;
    logic              rsp_zero;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic [3:0]        alu_ctrl;
    logic [31:0]       alu_in1;
    logic [31:0]       alu_in2;
    logic [31:0]       alu_result;
    logic              alu_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign req_ctrl = {p_ctrl[1], p_ctrl[0]};
    assign req_in1  = {p_a[1], p_a[0]};
    assign req_in2  = {p_b[1], p_b[0]};

    // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
    // 8 SLTU, 9 SLT, anything else returns 0.
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return (a < b) ? 32'd1 : 32'd0;
            4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_ctrl, alu_in1, alu_in2);
    assign alu_zero   = (alu_result == 32'd0);

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_ctrl_i   (req_ctrl),
        .req_in1_i    (req_in1),
        .req_in2_i    (req_in2),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_zero_o   (rsp_zero),
        .grant_id_o   (grant_id),
        .busy_o       (busy),
        .alu_ctrl_o   (alu_ctrl),
        .alu_in1_o    (alu_in1),
        .alu_in2_o    (alu_in2),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_busy;
    int          m_owner;
    int          m_last;      // last granted requester
    logic [31:0] m_result;
    bit          m_zero;

    // First valid requester after the last grant, wrapping around; -1 if none.
    function automatic int model_winner();
        for (int s = 1; s <= NREQ; s++) begin
            int k;
            k = (m_last + s) % NREQ;
            if (req_valid[IDW'(k)]) return k;
        end
        return -1;
    endfunction

    function automatic bit model_accept();
        return !m_busy || rsp_ready[IDW'(m_owner)];
    endfunction

    function automatic int model_issue();
        return model_accept() ? model_winner() : -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_owner  <= 0;
            m_last   <= NREQ - 1;
            m_result <= 32'd0;
            m_zero   <= 1'b0;
        end else if (model_issue() >= 0) begin
            m_busy   <= 1'b1;
            m_owner  <= model_issue();
            m_last   <= model_issue();
            m_result <= alu_fn(p_ctrl[IDW'(model_issue())], p_a[IDW'(model_issue())],
                               p_b[IDW'(model_issue())]);
            m_zero   <= (alu_fn(p_ctrl[IDW'(model_issue())], p_a[IDW'(model_issue())],
                                p_b[IDW'(model_issue())]) == 32'd0);
        end else if (m_busy && rsp_ready[IDW'(m_owner)]) begin
            m_busy   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int w;
            w = model_issue();
            check("m_req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
            check("m_alu_ctrl", 32'(alu_ctrl), (w >= 0) ? 32'(p_ctrl[IDW'(w)]) : 32'd0);
            check("m_alu_in1", alu_in1, (w >= 0) ? p_a[IDW'(w)] : 32'd0);
            check("m_alu_in2", alu_in2, (w >= 0) ? p_b[IDW'(w)] : 32'd0);
            check("m_busy", 32'(busy), 32'(m_busy));
            check("m_rsp_valid", 32'(rsp_valid), m_busy ? (32'd1 << m_owner) : 32'd0);
            check("m_result", rsp_result, m_result);
            check("m_zero", 32'(rsp_zero), 32'(m_zero));
            check("m_grant_id", 32'(grant_id), 32'(m_owner));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[IDW'(k)] = v;
        p_ctrl[IDW'(k)]    = c;
        p_a[IDW'(k)]       = a;
        p_b[IDW'(k)]       = b;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            p_ctrl[k] = 4'd0;
            p_a[k]    = 32'd0;
            p_b[k]    = 32'd0;
        end
        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_zero", 32'(rsp_zero), 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        tick();
        rst_n = 1'b1;

        // T1 single op: 5 + 7
        set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'd1);
        check("t1_alu_in1", alu_in1, 32'd5);
        tick();
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_result", rsp_result, 32'd12);
        check("t1_zero", 32'(rsp_zero), 32'd0);
        check("t1_grant", 32'(grant_id), 32'd0);
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        rsp_ready = 2'b01;
        tick();
        check("t1_release", 32'(busy), 32'd0);

        // T2 contention from reset
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
        set_req(1, 1'b1, 4'd0, 32'd2, 32'd2);
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_ready", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check("t2_grant", 32'(grant_id), 32'(i % 2));
        end
        req_valid = '0;
        tick();

        // T3 backpressure: 9 - 9 held while req0 waits
        rsp_ready = 2'b00;
        set_req(1, 1'b1, 4'd1, 32'd9, 32'd9);
        @(negedge clk);
        check("t3_ready1", 32'(req_ready), 32'd2);
        tick();
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_ready", 32'(req_ready), 32'd0);
            check("t3_hold_result", rsp_result, 32'd0);
            check("t3_hold_zero", 32'(rsp_zero), 32'd1);
            check("t3_hold_grant", 32'(grant_id), 32'd1);
            tick();
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        check("t3_regrant", 32'(req_ready), 32'd1);
        tick();
        check("t3_grant0", 32'(grant_id), 32'd0);
        check("t3_result", rsp_result, 32'd3);
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        rsp_ready = 2'b01;
        tick();

        // T4 signed vs unsigned compare, back to back, then an illegal code
        rsp_ready = 2'b11;
        set_req(0, 1'b1, 4'b1001, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("t4_slt", rsp_result, 32'd1);
        set_req(0, 1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("t4_sltu", rsp_result, 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        set_req(0, 1'b1, 4'b1111, 32'd5, 32'd5);
        tick();
        check("t6_illegal_result", rsp_result, 32'd0);
        check("t6_illegal_zero", 32'(rsp_zero), 32'd1);
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        tick();

        // T6 idle: ALU kept quiet
        @(negedge clk);
        check("t6_idle_ctrl", 32'(alu_ctrl), 32'd0);
        check("t6_idle_in1", alu_in1, 32'd0);
        check("t6_idle_in2", alu_in2, 32'd0);
        check("t6_idle_ready", 32'(req_ready), 32'd0);
        tick();

        // T5 reset mid-operation (pointer favours req1 beforehand)
        rsp_ready = 2'b00;
        set_req(0, 1'b1, 4'd0, 32'd3, 32'd4);
        set_req(1, 1'b1, 4'd0, 32'd6, 32'd6);
        tick();
        check("t5_pre_grant", 32'(grant_id), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(rsp_valid), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_req0_first", 32'(req_ready), 32'd1);
        tick();
        check("t5_grant", 32'(grant_id), 32'd0);
        check("t5_result", rsp_result, 32'd7);

        req_valid = '0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
